// File: rtl/ps2_transmitter_if.sv
// Host-side handshake and status bundle for the PS/2 host-to-device transmitter.
interface ps2_transmitter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, ack_err, timeout_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, ack_err, timeout_err
    );
endinterface

// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device command transmitter: inhibits the keyboard clock, drives the
// start bit, then shifts data/parity/stop on device clock falls and checks the ACK.
module ps2_transmitter #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_CYCLES  = 19
) (
    input  logic             clk,
    input  logic             rst,
    ps2_transmitter_if.slave host,
    input  logic             kclk_in,
    input  logic             kdata_in,
    output logic             kclk_oe,
    output logic             kdata_oe
);
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FLT_W   = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FILTER_LAST  = FLT_W'(FILTER_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, FINISH} state_t;

    // Bit 0 carries kclk, bit 1 carries kdata through the conditioning chain.
    logic [1:0]       raw;
    logic [1:0]       sync_a;
    logic [1:0]       sync_b;
    logic [1:0]       filt;
    logic [FLT_W-1:0] flt_cnt [2];
    logic             kclk_prev;
    logic             kclk_fall;
    logic             kclk_edge;

    assign raw = {kdata_in, kclk_in};

    // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= 2'b11;
            sync_b <= 2'b11;
            filt   <= 2'b11;
            for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FILTER_LAST) begin
                    filt[i]    <= sync_b[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + FLT_W'(1);
                end
            end
        end
    end

    assign kclk_fall = kclk_prev & ~filt[0];
    assign kclk_edge = kclk_prev ^ filt[0];

    state_t           state;
    logic [9:0]       frame;
    logic [3:0]       bit_idx;
    logic [CNT_W-1:0] cnt;
    logic             done_r;
    logic             ack_err_r;
    logic             timeout_err_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            frame         <= '0;
            bit_idx       <= '0;
            cnt           <= '0;
            kclk_prev     <= 1'b1;
            kclk_oe       <= 1'b0;
            kdata_oe      <= 1'b0;
            done_r        <= 1'b0;
            ack_err_r     <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            kclk_prev <= filt[0];
            done_r    <= 1'b0;
            case (state)
                IDLE: begin
                    if (host.tx_valid) begin
                        frame         <= {1'b1, ~^host.tx_data, host.tx_data};
                        ack_err_r     <= 1'b0;
                        timeout_err_r <= 1'b0;
                        cnt           <= '0;
                        kclk_oe       <= 1'b1;
                        kdata_oe      <= 1'b0;
                        state         <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == INHIBIT_LAST) begin
                        cnt      <= '0;
                        kdata_oe <= 1'b1;
                        state    <= REQ;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                REQ: begin
                    kclk_oe <= 1'b0;
                    bit_idx <= '0;
                    cnt     <= '0;
                    state   <= SEND;
                end
                SEND, ACK, FINISH: begin
                    // The rising edge after our own clock release also clears the watchdog.
                    cnt <= kclk_edge ? '0 : cnt + CNT_W'(1);
                    if (!kclk_edge && cnt == TIMEOUT_LAST) begin
                        kclk_oe       <= 1'b0;
                        kdata_oe      <= 1'b0;
                        done_r        <= 1'b1;
                        timeout_err_r <= 1'b1;
                        ack_err_r     <= 1'b0;
                        state         <= IDLE;
                    end else if (state == SEND) begin
                        if (kclk_fall) begin
                            kdata_oe <= ~frame[bit_idx];
                            if (bit_idx == 4'd9) state <= ACK;
                            else bit_idx <= bit_idx + 4'd1;
                        end
                    end else if (state == ACK) begin
                        if (kclk_fall) begin
                            ack_err_r <= filt[1];
                            state     <= FINISH;
                        end
                    end else if (filt == 2'b11) begin
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign host.tx_ready    = (state == IDLE);
    assign host.busy        = (state != IDLE);
    assign host.done        = done_r;
    assign host.ack_err     = ack_err_r;
    assign host.timeout_err = timeout_err_r;
endmodule

// File: tb/tb_ps2_transmitter.sv
// Scoreboard bench for ps2_transmitter with an open-drain PS/2 keyboard model.
module tb_ps2_transmitter;
    localparam int INHIBIT = 300;
    localparam int TIMEOUT = 1000;
    localparam int FILTER  = 19;
    localparam int HALF    = 100;

    typedef struct packed {
        logic ack_err;
        logic timeout_err;
    } done_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic kclk_oe;
    logic kdata_oe;
    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;
    logic glitch  = 1'b0;
    logic kclk_line;
    logic kdata_line;

    int n_cmp  = 0;
    int n_fail = 0;

    done_exp_t  exp_done_q[$];
    logic [9:0] exp_frame_q[$];
    logic [9:0] obs_frame;
    event       obs_ev;

    assign kclk_line  = ~kclk_oe & dev_clk & ~glitch;
    assign kdata_line = ~kdata_oe & dev_dat;

    ps2_transmitter_if bus ();

    ps2_transmitter #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT),
        .FILTER_CYCLES (FILTER)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .host    (bus),
        .kclk_in (kclk_line),
        .kdata_in(kdata_line),
        .kclk_oe (kclk_oe),
        .kdata_oe(kdata_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one command and record what the monitors must later see for it.
    task automatic send(input logic [7:0] d, input logic par, input bit exp_done,
                        input bit exp_ack_err, input bit exp_to, input bit exp_frame);
        done_exp_t e;
        @(negedge clk);
        check("tx_ready_before_send", 32'(bus.tx_ready), 1);
        e.ack_err     = exp_ack_err;
        e.timeout_err = exp_to;
        if (exp_done) exp_done_q.push_back(e);
        if (exp_frame) exp_frame_q.push_back({1'b1, par, d});
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        check("busy_after_accept", 32'(bus.busy), 1);
    endtask

    // Keyboard model: waits for the request-to-send, then clocks n_edges falls.
    task automatic dev_run(input int n_edges, input bit ack, input bit do_glitch);
        logic [9:0] obs;
        int         wait_cnt;
        obs      = '0;
        wait_cnt = 0;
        while (!(kclk_line && !kdata_line) && wait_cnt < 2000) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("request_start_bit_seen", 32'(kclk_line && !kdata_line), 1);
        if (!(kclk_line && !kdata_line)) return;
        for (int k = 1; k <= n_edges; k++) begin
            if (k == 11 && ack) dev_dat = 1'b0;
            if (do_glitch) begin
                repeat (HALF / 2) @(negedge clk);
                glitch = 1'b1;
                repeat (5) @(negedge clk);
                glitch = 1'b0;
                repeat (HALF - HALF / 2 - 5) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (k <= 10) obs[k-1] = kdata_line;
            dev_clk = 1'b1;
        end
        if (n_edges == 11) begin
            repeat (HALF) @(negedge clk);
            dev_dat   = 1'b1;
            obs_frame = obs;
            -> obs_ev;
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (bus.busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", 32'(bus.busy), 0);
        repeat (5) @(negedge clk);
    endtask

    // Frame monitor: compares each completed frame seen on the wire.
    initial begin
        logic [9:0] ef;
        forever begin
            @(obs_ev);
            check("frame_was_expected", 32'(exp_frame_q.size() > 0), 1);
            if (exp_frame_q.size() > 0) begin
                ef = exp_frame_q.pop_front();
                check("frame_bits", 32'(obs_frame), 32'(ef));
            end
        end
    end

    // Completion monitor: every done pulse must match a queued expectation.
    initial begin
        done_exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                check("done_was_expected", 32'(exp_done_q.size() > 0), 1);
                if (exp_done_q.size() > 0) begin
                    e = exp_done_q.pop_front();
                    check("ack_err", 32'(bus.ack_err), 32'(e.ack_err));
                    check("timeout_err", 32'(bus.timeout_err), 32'(e.timeout_err));
                    check("busy_low_at_done", 32'(bus.busy), 0);
                    check("lines_released_at_done", 32'({kclk_oe, kdata_oe}), 0);
                    @(negedge clk);
                    check("done_one_cycle", 32'(bus.done), 0);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_oe", 32'({kclk_oe, kdata_oe}), 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_flags", 32'({bus.done, bus.ack_err, bus.timeout_err}), 0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(bus.tx_ready), 1);

        // 0xF4 with inhibit/request timing checks.
        send(8'hF4, 1'b0, 1, 0, 0, 1);
        n = 0;
        while (kclk_oe && !kdata_oe && n < INHIBIT + 10) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_cycles", 32'(n), INHIBIT);
        check("req_both_driven", 32'({kclk_oe, kdata_oe}), 3);
        @(negedge clk);
        check("send_clk_released_start_low", 32'({kclk_oe, kdata_oe}), 1);
        dev_run(11, 1, 0);
        wait_idle(2000);

        send(8'h00, 1'b1, 1, 0, 0, 1);
        dev_run(11, 1, 0);
        wait_idle(2000);

        send(8'hFF, 1'b1, 1, 0, 0, 1);
        dev_run(11, 1, 0);
        wait_idle(2000);

        // Device withholds the ACK.
        send(8'hED, 1'b1, 1, 1, 0, 1);
        dev_run(11, 0, 0);
        wait_idle(2000);

        // Short low glitches on kclk must not advance the frame.
        send(8'h3C, 1'b1, 1, 0, 0, 1);
        dev_run(11, 1, 1);
        wait_idle(2000);

        // Device never clocks.
        send(8'hED, 1'b1, 1, 0, 1, 0);
        n = 0;
        while (kclk_oe && n < INHIBIT + 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!bus.done && n < TIMEOUT + 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency_in_range", 32'(n >= TIMEOUT && n <= TIMEOUT + 60), 1);
        wait_idle(100);

        // Reset in the middle of SEND after bit 4 has been driven.
        send(8'hA5, 1'b1, 0, 0, 0, 0);
        dev_run(5, 0, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("async_reset_releases_lines", 32'({kclk_oe, kdata_oe}), 0);
        check("async_reset_busy", 32'(bus.busy), 0);
        check("async_reset_no_done", 32'(bus.done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);

        send(8'h07, 1'b0, 1, 0, 0, 1);
        dev_run(11, 1, 0);
        wait_idle(2000);

        repeat (10) @(negedge clk);
        check("pending_done_expectations", 32'(exp_done_q.size()), 0);
        check("pending_frame_expectations", 32'(exp_frame_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_transmitter.md
Name: ps2_transmitter

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) from the FPGA to the keyboard on the shared kclk/kdata open-drain lines.
- Runs alongside the existing PS/2 receive path. Exposes drive-low enables (no IOBUF inside), so the top level ORs these with the pad tri-state controls.
- While busy, the receive path must ignore line activity.

Parameters:
- INHIBIT_CYCLES, 12000: clk cycles kclk is held low to request send (120 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000: max clk cycles between device clock edges, or before the first edge (20 ms).
- FILTER_CYCLES, 19: consecutive stable samples needed before a filtered kclk/kdata level changes.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- tx_data  in  8  byte to send
- tx_valid  in  1  send request
- tx_ready  out  1  high only in IDLE; the byte is accepted when tx_valid && tx_ready
- kclk_in  in  1  raw kclk pad level
- kdata_in  in  1  raw kdata pad level
- kclk_oe  out  1  1 = drive kclk low, 0 = release
- kdata_oe  out  1  1 = drive kdata low, 0 = release
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a transfer ends (success, ack error, or timeout)
- ack_err  out  1  valid with done: device did not ACK
- timeout_err  out  1  valid with done: timeout occurred

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - kclk_oe=kdata_oe=0; done=ack_err=timeout_err=busy=0; tx_ready=1 after release.
  - Synchronizers and filters are preset to 1; counters cleared.
- Input conditioning:
  - 2-FF synchronizer per line, then a stability filter of FILTER_CYCLES samples.
  - Falling/rising edge of filtered kclk = one-cycle strobe.
- Accept: in IDLE, tx_valid && tx_ready latches tx_data and computes parity = ~^tx_data (odd parity). Next state INHIBIT.
- INHIBIT: kclk_oe=1, kdata_oe=0 for INHIBIT_CYCLES cycles, then REQ.
- REQ:
  - kdata_oe=1 (start bit 0), kclk_oe stays 1 for exactly 1 further cycle, then kclk_oe=0.
  - Go to SEND with bit index 0; timeout counter cleared.
- SEND:
  - kdata_oe keeps driving start=0 until the first kclk falling edge.
  - Frame bits k=0..9 = data[0..7], parity, stop(1), LSB first.
  - On kclk falling edge number k+1, set kdata_oe = ~frame[k] in the cycle after the strobe.
  - On the stop-bit edge (falling edge 10), kdata_oe=0. Then go to ACK.
- ACK:
  - On the next kclk falling edge (11th), sample filtered kdata: 0 = ACK, 1 = ack_err.
  - Go to FINISH.
- FINISH:
  - Wait until filtered kclk=1 and kdata=1.
  - Then pulse done=1 for one cycle with ack_err set accordingly; go to IDLE.
  - ack_err/timeout_err hold until the next accept.
- Timeout:
  - In SEND/ACK/FINISH the counter increments every clk and clears on any filtered kclk edge.
  - Reaching TIMEOUT_CYCLES: kclk_oe=kdata_oe=0 immediately; done=1, timeout_err=1, ack_err=0; go to IDLE.
- tx_valid in non-IDLE states is ignored (no queueing).
- Reset mid-transfer: lines are released asynchronously, no done pulse.
- kclk_oe and kdata_oe are never both 0 between accept and the first SEND falling edge, except as specified above.

Test Plan:
- Send 0xF4 with a device model clocking at 12 kHz (period ≈ 8333 clk at 100 MHz):
  - kclk held low 12000 cycles, start=0.
  - Bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - Model ACKs → done=1, ack_err=0, timeout_err=0, busy falls after lines idle high.
- Send 0x00 → parity bit 1 observed on falling edge 9. Send 0xFF → parity 1; both ACKed, done pulse width exactly 1 cycle.
- Send 0xED, device model does not pull data low on the 11th clock → done=1, ack_err=1.
- Send 0xED, device never clocks → after INHIBIT+REQ plus 2000000 cycles: lines released, done=1, timeout_err=1.
- Glitch: 5-cycle low pulses on kclk_in during SEND → no bit advance; frame still correct.
- Assert rst=0 mid-SEND (after bit 4) → kclk_oe=kdata_oe=0 in the same cycle, busy=0, no done. A new send of 0x07 after release completes with parity 0.
